serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add/subtract engine: one full-adder slice plus a carry flop, sequenced LSB-first over WIDTH cycles.
//  Trades WIDTH-cycle latency for a single adder cell.
//  Sits between an upstream operand source and a downstream consumer.
//  Uses valid/ready handshakes on both sides; one operation in flight at a time.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a_in/b_in/sub_in are valid
//  in_ready   out  1      engine can accept operands (high only in IDLE)
//  a_in       in   WIDTH  operand A (two's complement or unsigned)
//  b_in       in   WIDTH  operand B
//  sub_in     in   1      0: A+B, 1: A-B
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum_out    out  WIDTH  result bits
//  c_out      out  1      final carry; for subtract, 1 = no borrow
//  ovf_out    out  1      signed overflow = carry into MSB XOR carry out of MSB
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  FSM has three states: IDLE, RUN, DONE.
//  Reset (async, rst_n=0):
//   - state=IDLE, bit counter=0, operand/result shift regs=0, carry=0.
//   - sum_out=0, c_out=0, ovf_out=0, out_valid=0, busy=0, in_ready=1.
//  IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
//   - latch A, B^{WIDTH{sub_in}}, carry<=sub_in, counter<=0, go to RUN.
//  RUN: in_ready=0. On each edge:
//   - sum bit = A[0]^B'[0]^carry; carry <= majority(A[0], B'[0], carry).
//   - Shift A and B' right one bit; shift the sum bit into the result MSB; counter++.
//   - On the edge processing bit WIDTH-1, also capture carry-in of that bit (for ovf).
//   - Go to DONE on that edge.
//  Latency: out_valid rises on edge E_WIDTH, i.e. exactly WIDTH cycles after the accept edge.
//  DONE: out_valid=1. sum_out/c_out/ovf_out are stable and held while out_ready=0 (unbounded backpressure).
//   - On out_valid&&out_ready: go to IDLE. in_ready=1 the following cycle.
//   - A new operand cannot be accepted in the same cycle as the result handshake.
//  sum_out/c_out/ovf_out keep their last values in IDLE until the next op's DONE.
//   - Consumers must only sample them while out_valid=1.
//  in_valid while busy: ignored, no side effects; upstream must hold its data until in_ready.
//  Counter width $clog2(WIDTH); counter wraps to 0 on the RUN->DONE edge.
//  Reset mid-RUN or mid-DONE: operation aborted; no partial result is ever presented.
//  Width rules: all arithmetic is modulo 2^WIDTH; no sign extension.
// STRUCTURE
//  Package serial_adder_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - CNT_W = $clog2(WIDTH).
//  Sub-module serial_fa_slice:
//   - combinational full adder (a, b, cin -> s, cout) plus the registered carry (clk, rst_n, load, load_val).
//  Top level holds the FSM, counter, operand shift regs, result reg and handshake logic.
// TESTING (WIDTH=8)
//  1. 0x5A + 0x33, sub=0 -> sum=0x8D, c_out=0, ovf=1; out_valid exactly 8 cycles after accept.
//  2. 0xFF + 0x01, sub=0 -> sum=0x00, c_out=1, ovf=0.
//  3. 0x10 - 0x20, sub=1 -> sum=0xF0, c_out=0 (borrow), ovf=0.
//     0x80 - 0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
//  4. out_ready low for 5 cycles in DONE -> out_valid and results held constant; IDLE one cycle after handshake.
//  5. in_valid pulsed with new operands during RUN -> ignored; result matches the original operands; in_ready stays 0.
//  6. rst_n asserted after 3 RUN cycles -> all outputs take reset values immediately;
//     after release, in_ready=1 and the next op 0x01+0x01 gives 0x02.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and sizing helpers for the bit-serial
//               add/subtract engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width for a given operand width (WIDTH >= 2 gives >= 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/serial_fa_slice.sv
// ============================================================================
// Module      : serial_fa_slice
// Description : Single full-adder cell with its registered carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  input  logic load_i,
  input  logic load_val_i,
  input  logic en_i,
  output logic s_o,
  output logic cout_o,
  output logic carry_o
);

  logic carry_q;
  logic carry_d;

  assign s_o     = a_i ^ b_i ^ carry_q;
  assign cout_o  = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
  assign carry_o = carry_q;

  always_comb begin
    carry_d = carry_q;
    if (load_i) begin
      carry_d = load_val_i;
    end else if (en_i) begin
      carry_d = cout_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract engine, LSB first, valid/ready on
//               both sides, one operation in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int unsigned        CTR_W    = cnt_width(WIDTH);
  localparam logic [CTR_W-1:0]   LAST_BIT = CTR_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CTR_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_q,     c_d;
  logic             ovf_q,   ovf_d;

  logic fa_load;
  logic fa_load_val;
  logic fa_en;
  logic fa_s;
  logic fa_cout;
  logic fa_carry;

  serial_fa_slice u_fa (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_i        (a_q[0]),
    .b_i        (b_q[0]),
    .load_i     (fa_load),
    .load_val_i (fa_load_val),
    .en_i       (fa_en),
    .s_o        (fa_s),
    .cout_o     (fa_cout),
    .carry_o    (fa_carry)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum_out   = sum_q;
  assign c_out     = c_q;
  assign ovf_out   = ovf_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    sum_d       = sum_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    fa_load     = 1'b0;
    fa_load_val = 1'b0;
    fa_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
          a_d         = a_in;
          b_d         = b_in ^ {WIDTH{sub_in}};
          fa_load     = 1'b1;
          fa_load_val = sub_in;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        fa_en = 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Outputs only update here so no partial result is ever visible.
          cnt_d   = '0;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          c_d     = fa_cout;
          ovf_d   = fa_carry ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sub_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         c_out;
  logic         ovf_out;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] last_sum;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sub_in    (sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .c_out     (c_out),
    .ovf_out   (ovf_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and sign-rule overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic v);
    int unsigned full;
    if (sub) full = int'(a) + ((1 << W) - int'(b));
    else     full = int'(a) + int'(b);
    s = full[W-1:0];
    c = full[W];
    if (sub) v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    else     v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] es, input logic ec, input logic ev,
                        input int hold, input bit inject);
    int lat;
    logic [W-1:0] held;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    sub_in   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    sub_in   = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (inject && lat >= 1 && lat <= 3) begin
        in_valid = 1'b1;
        a_in     = 8'hFF;
        b_in     = 8'hFF;
        sub_in   = 1'b1;
        check("in_ready_run", in_ready, 0);
        check("sum_held_run", sum_out, last_sum);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("sum", sum_out, es);
    check("c_out", c_out, ec);
    check("ovf", ovf_out, ev);
    held = sum_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum_out, held);
      check("hold_c", c_out, ec);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("ready_after_hs", in_ready, 1);
    check("sum_kept_idle", sum_out, es);
    last_sum = sum_out;
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rsub, ec, ev;

    vecs[0] = '{a: 8'h5A, b: 8'h33, sub: 1'b0, sum: 8'h8D, c: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, c: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, sum: 8'hF0, c: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, c: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, c: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, c: 1'b1, ovf: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    sub_in    = 1'b0;
    last_sum  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum_out, 0);
    check("rst_c", c_out, 0);
    check("rst_ovf", ovf_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].c, vecs[i].ovf, 0, 1'b0);
    end

    // Backpressure for five cycles.
    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 5, 1'b0);

    // New operands offered while running must be ignored.
    run_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 0, 1'b1);

    // Reset after three RUN cycles.
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 8'h5A;
    b_in     = 8'h33;
    sub_in   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sum", sum_out, 0);
    check("arst_c", c_out, 0);
    check("arst_ovf", ovf_out, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_sum = '0;
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rsub = 1'($urandom);
      model(ra, rb, rsub, es, ec, ev);
      run_op(ra, rb, rsub, es, ec, ev, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
